// File: rtl/vector_packer.sv
// vector_packer: packs a serial element stream into LANES-wide vectors.
// Two vector slots: the fill buffer (which doubles as the pending slot when
// the output is blocked) and the output register feeding the rearrange unit.
module vector_packer #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned LANES      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_WIDTH-1:0]         elem_in,
   input  logic                          elem_valid,
   output logic                          elem_ready,
   input  logic                          flush,
   output logic [LANES*DATA_WIDTH-1:0]   vec_out,
   output logic                          vec_valid,
   input  logic                          vec_ready,
   output logic [4:0]                    vec_count,
   output logic                          busy
);

   localparam int unsigned VEC_W = LANES * DATA_WIDTH;
   localparam int unsigned IDX_W = $clog2(LANES);
   localparam int unsigned CNT_W = 5;

   // Fill-side state: FILL accepts elements, PEND holds a closed vector
   // in the fill buffer until the output register drains.
   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] PEND = 1'b1;

   logic [0:0]       state_q,     state_d;
   logic [IDX_W-1:0] idx_q,       idx_d;
   logic [VEC_W-1:0] fill_q,      fill_d;
   logic [CNT_W-1:0] pend_cnt_q,  pend_cnt_d;
   logic [VEC_W-1:0] vec_out_q,   vec_out_d;
   logic [CNT_W-1:0] vec_count_q, vec_count_d;
   logic             vec_valid_q, vec_valid_d;
   logic             elem_ready_q, elem_ready_d;
   logic             busy_q,      busy_d;

   logic             accept;
   logic             drain;
   logic             out_free;
   logic             closing;
   logic [CNT_W-1:0] close_cnt;
   logic [VEC_W-1:0] fill_nxt;

   // Handshake qualifiers and the close condition for the current fill buffer.
   always_comb begin
      accept    = elem_valid && elem_ready_q;
      drain     = vec_valid_q && vec_ready;
      out_free  = !vec_valid_q || vec_ready;
      closing   = (state_q == FILL) && elem_ready_q &&
                  ((accept && (idx_q == IDX_W'(LANES - 1))) ||
                   (flush && ((idx_q != '0) || accept)));
      close_cnt = CNT_W'({1'b0, idx_q}) + CNT_W'(accept);
   end

   // Fill buffer with the accepted element written into lane idx.
   always_comb begin
      fill_nxt = fill_q;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (accept && (idx_q == IDX_W'(i))) begin
            fill_nxt[i*DATA_WIDTH +: DATA_WIDTH] = elem_in;
         end
      end
   end

   // Next-state and output-register computation.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      fill_d       = fill_q;
      pend_cnt_d   = pend_cnt_q;
      vec_out_d    = vec_out_q;
      vec_count_d  = vec_count_q;
      vec_valid_d  = vec_valid_q && !vec_ready;

      case (state_q)
         FILL: begin
            if (closing) begin
               idx_d = '0;
               if (out_free) begin
                  // Output slot free (or draining now): load directly, no bubble.
                  vec_out_d   = fill_nxt;
                  vec_count_d = close_cnt;
                  vec_valid_d = 1'b1;
                  fill_d      = '0;
               end else begin
                  // Output blocked: park the closed vector in the fill buffer.
                  state_d    = PEND;
                  fill_d     = fill_nxt;
                  pend_cnt_d = close_cnt;
               end
            end else begin
               fill_d = fill_nxt;
               idx_d  = idx_q + IDX_W'(accept);
            end
         end
         PEND: begin
            if (drain) begin
               vec_out_d   = fill_q;
               vec_count_d = pend_cnt_q;
               vec_valid_d = 1'b1;
               fill_d      = '0;
               pend_cnt_d  = '0;
               state_d     = FILL;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase

      elem_ready_d = (state_d == FILL);
      busy_d       = (idx_d != '0) || (state_d == PEND) || vec_valid_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FILL;
         idx_q        <= '0;
         fill_q       <= '0;
         pend_cnt_q   <= '0;
         vec_out_q    <= '0;
         vec_count_q  <= '0;
         vec_valid_q  <= 1'b0;
         elem_ready_q <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         fill_q       <= fill_d;
         pend_cnt_q   <= pend_cnt_d;
         vec_out_q    <= vec_out_d;
         vec_count_q  <= vec_count_d;
         vec_valid_q  <= vec_valid_d;
         elem_ready_q <= elem_ready_d;
         busy_q       <= busy_d;
      end
   end

   assign elem_ready = elem_ready_q;
   assign vec_out    = vec_out_q;
   assign vec_valid  = vec_valid_q;
   assign vec_count  = vec_count_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_vector_packer.sv
// Directed, table-driven bench for vector_packer.
module tb_vector_packer;

   localparam int unsigned DW = 16;
   localparam int unsigned LN = 16;
   localparam int unsigned VW = DW * LN;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] elem_in;
   logic          elem_valid;
   logic          elem_ready;
   logic          flush;
   logic [VW-1:0] vec_out;
   logic          vec_valid;
   logic          vec_ready;
   logic [4:0]    vec_count;
   logic          busy;

   int checks = 0;
   int errors = 0;

   vector_packer #(.DATA_WIDTH(DW), .LANES(LN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .elem_in    (elem_in),
      .elem_valid (elem_valid),
      .elem_ready (elem_ready),
      .flush      (flush),
      .vec_out    (vec_out),
      .vec_valid  (vec_valid),
      .vec_ready  (vec_ready),
      .vec_count  (vec_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          ev;
      logic [DW-1:0] d;
      logic          fl;
      logic          vr;
      logic          exp_vv;
      logic [4:0]    exp_cnt;
      logic          exp_er;
      logic          exp_busy;
      logic [VW-1:0] exp_vec;
   } row_t;

   row_t tbl[$];

   task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int lane, input logic [DW-1:0] d);
      logic [VW-1:0] r;
      r = v;
      r[lane*DW +: DW] = d;
      return r;
   endfunction

   function automatic row_t mk(input logic ev, input logic [DW-1:0] d, input logic fl, input logic vr,
                               input logic vv, input logic [4:0] cnt, input logic er, input logic bz,
                               input logic [VW-1:0] vec);
      row_t r;
      r.ev = ev; r.d = d; r.fl = fl; r.vr = vr;
      r.exp_vv = vv; r.exp_cnt = cnt; r.exp_er = er; r.exp_busy = bz; r.exp_vec = vec;
      return r;
   endfunction

   task automatic drive(input logic ev, input logic [DW-1:0] d, input logic fl, input logic vr);
      elem_valid = ev;
      elem_in    = d;
      flush      = fl;
      vec_ready  = vr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_vec_valid"},  VW'(vec_valid),  VW'(1'b0));
      chk({tag, "_vec_out"},    vec_out,         '0);
      chk({tag, "_vec_count"},  VW'(vec_count),  '0);
      chk({tag, "_elem_ready"}, VW'(elem_ready), VW'(1'b1));
      chk({tag, "_busy"},       VW'(busy),       VW'(1'b0));
   endtask

   initial begin
      logic [VW-1:0] ev1;
      logic [VW-1:0] ev2;
      logic [VW-1:0] ea;
      logic [VW-1:0] eb;
      logic [VW-1:0] ec;
      logic [VW-1:0] exp_q[$];
      logic [VW-1:0] got;
      logic [DW-1:0] lane;
      int            last_seen;
      int            n_seen;
      logic          er_drop;
      logic          spurious;

      drive(1'b0, '0, 1'b0, 1'b0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #11;
      chk_reset_vals("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // 16 back-to-back elements, output always ready
      ev1 = '0;
      er_drop = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ev1 = put(ev1, i, DW'(i + 1));
         drive(1'b1, DW'(i + 1), 1'b0, 1'b1);
         tick();
         if (!elem_ready) er_drop = 1'b1;
         if (i < 15) chk("full16_no_early_valid", VW'(vec_valid), VW'(1'b0));
      end
      chk("full16_valid", VW'(vec_valid), VW'(1'b1));
      chk("full16_count", VW'(vec_count), VW'(5'd16));
      chk("full16_vec", vec_out, ev1);
      got = vec_out;
      lane = got[0 +: DW];
      chk("full16_lane0", VW'(lane), VW'(16'h0001));
      lane = got[15*DW +: DW];
      chk("full16_lane15", VW'(lane), VW'(16'h0010));
      chk("full16_elem_ready_held", VW'(er_drop), VW'(1'b0));
      drive(1'b0, '0, 1'b0, 1'b1);
      tick();
      chk("full16_drained", VW'(vec_valid), VW'(1'b0));

      // 16th accept coincides with flush: one 16-lane close only
      ev1 = '0;
      for (int i = 0; i < 16; i++) begin
         ev1 = put(ev1, i, DW'(16'h3000 + i));
         drive(1'b1, DW'(16'h3000 + i), (i == 15), 1'b1);
         tick();
      end
      chk("last_flush_count", VW'(vec_count), VW'(5'd16));
      chk("last_flush_vec", vec_out, ev1);
      drive(1'b0, '0, 1'b1, 1'b1);
      tick();
      chk("last_flush_no_extra", VW'(vec_valid), VW'(1'b0));
      chk("last_flush_idle_busy", VW'(busy), VW'(1'b0));

      // Table: partial flush, hold, empty flush, accept+flush, drain+close
      ea = '0;
      for (int i = 0; i < 5; i++) ea = put(ea, i, DW'(16'hA000 + i));
      eb = '0;
      for (int i = 0; i < 3; i++) eb = put(eb, i, DW'(16'hB000 + i));
      ec = put('0, 0, 16'hC000);
      ev2 = put('0, 0, 16'hC001);
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1'b1, DW'(16'hA000 + i), 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, '0));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, ea));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, ea));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, '0));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, '0));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, '0));
      tbl.push_back(mk(1'b1, 16'hB000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, '0));
      tbl.push_back(mk(1'b1, 16'hB001, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, '0));
      tbl.push_back(mk(1'b1, 16'hB002, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, eb));
      tbl.push_back(mk(1'b1, 16'hC000, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, ec));
      tbl.push_back(mk(1'b1, 16'hC001, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, ev2));
      tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, '0));
      foreach (tbl[k]) begin
         drive(tbl[k].ev, tbl[k].d, tbl[k].fl, tbl[k].vr);
         tick();
         chk($sformatf("tbl%0d_vec_valid", k), VW'(vec_valid), VW'(tbl[k].exp_vv));
         chk($sformatf("tbl%0d_elem_ready", k), VW'(elem_ready), VW'(tbl[k].exp_er));
         chk($sformatf("tbl%0d_busy", k), VW'(busy), VW'(tbl[k].exp_busy));
         if (tbl[k].exp_vv) begin
            chk($sformatf("tbl%0d_count", k), VW'(vec_count), VW'(tbl[k].exp_cnt));
            chk($sformatf("tbl%0d_vec", k), vec_out, tbl[k].exp_vec);
         end
      end

      // Backpressure: 32 elements with output blocked
      ev1 = '0;
      ev2 = '0;
      for (int i = 0; i < 16; i++) begin
         ev1 = put(ev1, i, DW'(16'h1100 + i));
         ev2 = put(ev2, i, DW'(16'h1200 + i));
      end
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, (i < 16) ? DW'(16'h1100 + i) : DW'(16'h1200 + i - 16), 1'b0, 1'b0);
         tick();
         if (i == 15) begin
            chk("bp_first_valid", VW'(vec_valid), VW'(1'b1));
            chk("bp_first_vec", vec_out, ev1);
         end
         if (i > 15) chk($sformatf("bp_hold%0d", i), vec_out, ev1);
         if (i < 31) chk($sformatf("bp_ready%0d", i), VW'(elem_ready), VW'(1'b1));
      end
      chk("bp_pending_ready", VW'(elem_ready), VW'(1'b0));
      chk("bp_pending_busy", VW'(busy), VW'(1'b1));
      chk("bp_pending_count", VW'(vec_count), VW'(5'd16));
      drive(1'b1, 16'hDEAD, 1'b1, 1'b0);
      tick();
      chk("bp_blocked_ready", VW'(elem_ready), VW'(1'b0));
      chk("bp_blocked_vec", vec_out, ev1);
      drive(1'b0, '0, 1'b0, 1'b1);
      tick();
      chk("bp_second_valid", VW'(vec_valid), VW'(1'b1));
      chk("bp_second_vec", vec_out, ev2);
      chk("bp_second_count", VW'(vec_count), VW'(5'd16));
      chk("bp_ready_back", VW'(elem_ready), VW'(1'b1));
      drive(1'b0, '0, 1'b0, 1'b1);
      tick();
      chk("bp_drained", VW'(vec_valid), VW'(1'b0));
      chk("bp_idle_busy", VW'(busy), VW'(1'b0));

      // Continuous 64-element stream with scoreboard
      for (int v = 0; v < 4; v++) begin
         ev1 = '0;
         for (int l = 0; l < 16; l++) ev1 = put(ev1, l, DW'(16'h2000 + v * 16 + l));
         exp_q.push_back(ev1);
      end
      last_seen = -1;
      n_seen = 0;
      er_drop = 1'b0;
      for (int c = 0; c < 70; c++) begin
         if (c < 64) drive(1'b1, DW'(16'h2000 + c), 1'b0, 1'b1);
         else        drive(1'b0, '0, 1'b0, 1'b1);
         tick();
         if (!elem_ready) er_drop = 1'b1;
         if (vec_valid) begin
            n_seen++;
            if (exp_q.size() == 0) begin
               chk("stream_extra_vector", VW'(vec_valid), VW'(1'b0));
            end else begin
               ev1 = exp_q.pop_front();
               chk($sformatf("stream_vec%0d", n_seen), vec_out, ev1);
            end
            if (last_seen >= 0) chk($sformatf("stream_gap%0d", n_seen), VW'(c - last_seen), VW'(16));
            last_seen = c;
         end
      end
      chk("stream_vector_count", VW'(n_seen), VW'(4));
      chk("stream_ready_held", VW'(er_drop), VW'(1'b0));

      // Reset mid-fill (idx=9)
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, DW'(16'h4000 + i), 1'b0, 1'b1);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_fill");
      tick();
      rst_n = 1'b1;
      spurious = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, '0, 1'b1, 1'b1);
         tick();
         if (vec_valid) spurious = 1'b1;
      end
      chk("rst_fill_no_output", VW'(spurious), VW'(1'b0));

      // Reset while a vector is pending
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, DW'(16'h4100 + i), 1'b0, 1'b0);
         tick();
      end
      chk("rst_pend_setup", VW'(elem_ready), VW'(1'b0));
      drive(1'b0, '0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_pend");
      tick();
      rst_n = 1'b1;
      spurious = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, '0, 1'b0, 1'b1);
         tick();
         if (vec_valid) spurious = 1'b1;
      end
      chk("rst_pend_no_output", VW'(spurious), VW'(1'b0));

      // Next 16 elements pack from lane 0
      ev1 = '0;
      for (int i = 0; i < 16; i++) begin
         ev1 = put(ev1, i, DW'(16'h5000 + i));
         drive(1'b1, DW'(16'h5000 + i), 1'b0, 1'b1);
         tick();
      end
      chk("post_rst_valid", VW'(vec_valid), VW'(1'b1));
      chk("post_rst_count", VW'(vec_count), VW'(5'd16));
      chk("post_rst_vec", vec_out, ev1);
      drive(1'b0, '0, 1'b0, 1'b1);
      tick();
      chk("post_rst_drained", VW'(vec_valid), VW'(1'b0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_packer.md
Name: vector_packer

Overview:
- Stage directly upstream of the 16-lane data rearrange unit.
- Accepts a serial stream of scalar elements (one per handshake) and packs them into 16-lane vectors, lane 0 first.
- Presents each vector on a valid/ready output that feeds the rearrange stage's vector input.
- Two vector slots (fill buffer plus output register), so packing continues while a finished vector waits downstream.
- A flush input closes a partial vector with zero padding.

Parameters:
- DATA_WIDTH, 16, bits per element (matches codebase-wide DATA_WIDTH).
- LANES, 16, elements per vector. Fixed at 16 for this release.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- elem_in  input  DATA_WIDTH  scalar element.
- elem_valid  input  1  elem_in valid.
- elem_ready  output  1  packer can accept elem_in this cycle.
- flush  input  1  close current partial vector; level, sampled only when elem_ready=1.
- vec_out  output  LANES*DATA_WIDTH  packed vector; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- vec_valid  output  1  vec_out valid.
- vec_ready  input  1  downstream accepts vec_out.
- vec_count  output  5  number of populated lanes in vec_out, 1..16.
- busy  output  1  high when fill index != 0, a vector is pending, or vec_valid=1.

Behaviour:
- Reset (async assert, sync release):
  - vec_valid=0, vec_out=0, vec_count=0, elem_ready=1, busy=0.
  - Fill index idx=0, pending=0, fill buffer cleared to zero.
  - Reset mid-operation discards partial and pending vectors; no output is produced for them.
- Element accept: elem_valid && elem_ready on a rising edge.
  - elem_in is written to fill lane idx; idx increments by 1.
- Vector close. The fill buffer closes when either:
  - an element is accepted with idx==15 (count 16), or
  - flush=1 with elem_ready=1 and (idx>0 or an element is accepted that same cycle).
  - Count on close = idx + (1 if an element is accepted that cycle).
  - Lanes >= count are zero.
  - flush with idx==0 and no element accept: ignored, no output.
- Transfer to output register on close:
  - The output slot is free if vec_valid==0, or if vec_valid && vec_ready this cycle.
  - If free: next cycle vec_out/vec_count load, vec_valid=1, fill buffer zeroed, idx=0.
  - Latency is 1 cycle from the closing accept edge to vec_valid.
  - If not free: pending=1, idx=0, elem_ready=0. The first cycle the output drains, the pending vector moves to the output register (vec_valid stays 1 with new data) and pending clears.
- elem_ready = !pending (registered). Never depends combinationally on elem_valid.
- Output hold: while vec_valid && !vec_ready, vec_out and vec_count are stable.
  - vec_valid && vec_ready with nothing pending or closing: vec_valid=0 next cycle.
- Throughput: with vec_ready held high, sustains 1 element/cycle indefinitely; a 16-element vector appears every 16 cycles.
- Simultaneous events:
  - An accept at idx==15 together with flush: a single 16-lane close (flush has no extra effect).
  - A drain on the same cycle as a close: the new vector loads directly, no bubble.
- State machine (one-hot or encoded):
  - FILL: pending=0.
  - PEND: pending=1, elem_ready=0. Goes to FILL on drain.
  - Output validity is tracked independently by vec_valid.
- Width: idx is 4 bits, wraps to 0 on every close; vec_count is 5 bits.

Test Plan:
- Reset, then 16 elements 0x0001..0x0010 on back-to-back cycles, vec_ready=1 -> one cycle after the 16th accept vec_valid=1, lane0=0x0001, lane15=0x0010, vec_count=16; elem_ready never drops.
- 5 elements 0xA000..0xA004, then flush alone -> vec_count=5, lanes 0-4 = 0xA000..0xA004, lanes 5-15 = 0; a flush with an empty buffer produces no vector.
- vec_ready=0, 32 elements streamed:
  - the first vector is held stable;
  - the second vector sets pending, and elem_ready=0 from the cycle after the 32nd accept;
  - raising vec_ready for 1 cycle -> the second vector is presented next cycle and elem_ready returns to 1.
- Continuous 64-element stream with vec_ready=1 -> 4 vectors exactly 16 cycles apart; no data loss or reordering (scoreboard).
- 3rd element accepted with flush in the same cycle -> vec_count=3; the next vector starts at lane 0.
- Assert rst_n=0 mid-fill (idx=9) and while pending -> all outputs reach their reset values immediately; no vector is emitted after release; the next 16 elements pack from lane 0.
